// File: rtl/uart_cfg_if.sv
// Host-side bundle for uart_cfg: baud/parity config, FIFO push/pop, serial lines and status.
// The DUT uses the slave modport; whatever drives it uses master.
interface uart_cfg_if #(
   parameter int unsigned DBIT   = 8,
   parameter int unsigned DVSR_W = 11
);
   logic [DVSR_W-1:0] dvsr;
   logic [1:0]        par_mode;
   logic              wr_uart;
   logic [DBIT-1:0]   w_data;
   logic              rd_uart;
   logic              clr_err;
   logic              rx;
   logic              tx;
   logic              tx_full;
   logic              tx_idle;
   logic              rx_empty;
   logic [DBIT-1:0]   r_data;
   logic              frame_err;
   logic              parity_err;
   logic              overrun_err;

   modport master (
      output dvsr, par_mode, wr_uart, w_data, rd_uart, clr_err, rx,
      input  tx, tx_full, tx_idle, rx_empty, r_data, frame_err, parity_err, overrun_err
   );

   modport slave (
      input  dvsr, par_mode, wr_uart, w_data, rd_uart, clr_err, rx,
      output tx, tx_full, tx_idle, rx_empty, r_data, frame_err, parity_err, overrun_err
   );
endinterface

// File: rtl/uart_cfg.sv
// UART with runtime baud divisor, 16x oversampled RX, and FWFT TX/RX FIFOs.
// Parity support is compiled in only when UART_CFG_PARITY_EN is defined.
module uart_cfg #(
   parameter int unsigned DBIT    = 8,
   parameter int unsigned SB_TICK = 16,
   parameter int unsigned DVSR_W  = 11,
   parameter int unsigned FIFO_W  = 2
) (
   input logic       clk,
   input logic       rst_n,
   uart_cfg_if.slave u
);

   localparam int unsigned SW    = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
   localparam int unsigned NW    = (DBIT > 1) ? $clog2(DBIT) : 1;
   localparam int unsigned DEPTH = 1 << FIFO_W;

   localparam logic [SW-1:0] SMid  = SW'(7);
   localparam logic [SW-1:0] SBit  = SW'(15);
   localparam logic [SW-1:0] SStop = SW'(SB_TICK - 1);
   localparam logic [NW-1:0] NLast = NW'(DBIT - 1);

   typedef enum logic [2:0] {StIdle, StStart, StData, StPar, StStop} state_e;

   logic [1:0] par_mode_in;

   // Baud generator
   logic [DVSR_W-1:0] baud_q, baud_d;
   logic              tick;

   assign tick   = (baud_q == u.dvsr);
   assign baud_d = tick ? '0 : baud_q + DVSR_W'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) baud_q <= '0;
      else        baud_q <= baud_d;
   end

   // RX synchronizer
   logic rx_meta_q, rx_sync_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_meta_q <= 1'b1;
         rx_sync_q <= 1'b1;
      end else begin
         rx_meta_q <= u.rx;
         rx_sync_q <= rx_meta_q;
      end
   end

   // TX FIFO
   logic [DBIT-1:0] txf_mem_q [DEPTH];
   logic [FIFO_W:0] txf_wp_q, txf_rp_q;
   logic            txf_full, txf_empty, txf_we, txf_re, tx_pop;
   logic [DBIT-1:0] txf_head;

   assign txf_empty = (txf_wp_q == txf_rp_q);
   assign txf_full  = (txf_wp_q[FIFO_W] != txf_rp_q[FIFO_W]) &&
                      (txf_wp_q[FIFO_W-1:0] == txf_rp_q[FIFO_W-1:0]);
   assign txf_re    = tx_pop & ~txf_empty;
   assign txf_we    = u.wr_uart & (~txf_full | txf_re);
   assign txf_head  = txf_mem_q[txf_rp_q[FIFO_W-1:0]];

   always_ff @(posedge clk) begin
      if (txf_we) txf_mem_q[txf_wp_q[FIFO_W-1:0]] <= u.w_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         txf_wp_q <= '0;
         txf_rp_q <= '0;
      end else begin
         if (txf_we) txf_wp_q <= txf_wp_q + 1'b1;
         if (txf_re) txf_rp_q <= txf_rp_q + 1'b1;
      end
   end

   // RX FSM
   state_e          rx_st_q, rx_st_d;
   logic [SW-1:0]   rx_s_q, rx_s_d;
   logic [NW-1:0]   rx_n_q, rx_n_d;
   logic [DBIT-1:0] rx_b_q, rx_b_d;
   logic [1:0]      rx_mode_q, rx_mode_d;
   logic            rx_pbit_q, rx_pbit_d;
   logic            rx_done_q, rx_done_d;
   logic            rx_ferr_set;

   always_comb begin
      rx_st_d     = rx_st_q;
      rx_s_d      = rx_s_q;
      rx_n_d      = rx_n_q;
      rx_b_d      = rx_b_q;
      rx_mode_d   = rx_mode_q;
      rx_pbit_d   = rx_pbit_q;
      rx_done_d   = 1'b0;
      rx_ferr_set = 1'b0;
      unique case (rx_st_q)
         StIdle: begin
            if (!rx_sync_q) begin
               rx_st_d   = StStart;
               rx_s_d    = '0;
               rx_mode_d = par_mode_in;
            end
         end
         StStart: begin
            if (tick) begin
               if (rx_s_q == SMid) begin
                  rx_s_d  = '0;
                  rx_n_d  = '0;
                  rx_st_d = rx_sync_q ? StIdle : StData;
               end else begin
                  rx_s_d = rx_s_q + SW'(1);
               end
            end
         end
         StData: begin
            if (tick) begin
               if (rx_s_q == SBit) begin
                  rx_s_d = '0;
                  rx_b_d = {rx_sync_q, rx_b_q[DBIT-1:1]};
                  if (rx_n_q == NLast) rx_st_d = (^rx_mode_q) ? StPar : StStop;
                  else                 rx_n_d  = rx_n_q + NW'(1);
               end else begin
                  rx_s_d = rx_s_q + SW'(1);
               end
            end
         end
         StPar: begin
            if (tick) begin
               if (rx_s_q == SBit) begin
                  rx_s_d    = '0;
                  rx_pbit_d = rx_sync_q;
                  rx_st_d   = StStop;
               end else begin
                  rx_s_d = rx_s_q + SW'(1);
               end
            end
         end
         StStop: begin
            if (tick) begin
               if (rx_s_q == SStop) begin
                  rx_st_d     = StIdle;
                  rx_done_d   = rx_sync_q;
                  rx_ferr_set = ~rx_sync_q;
               end else begin
                  rx_s_d = rx_s_q + SW'(1);
               end
            end
         end
         default: rx_st_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_st_q   <= StIdle;
         rx_s_q    <= '0;
         rx_n_q    <= '0;
         rx_b_q    <= '0;
         rx_mode_q <= 2'b00;
         rx_pbit_q <= 1'b0;
         rx_done_q <= 1'b0;
      end else begin
         rx_st_q   <= rx_st_d;
         rx_s_q    <= rx_s_d;
         rx_n_q    <= rx_n_d;
         rx_b_q    <= rx_b_d;
         rx_mode_q <= rx_mode_d;
         rx_pbit_q <= rx_pbit_d;
         rx_done_q <= rx_done_d;
      end
   end

   // RX FIFO; a pop in the same cycle frees the slot for the incoming byte
   logic [DBIT-1:0] rxf_mem_q [DEPTH];
   logic [FIFO_W:0] rxf_wp_q, rxf_rp_q;
   logic            rxf_full, rxf_empty, rxf_we, rxf_re, ovr_set;

   assign rxf_empty = (rxf_wp_q == rxf_rp_q);
   assign rxf_full  = (rxf_wp_q[FIFO_W] != rxf_rp_q[FIFO_W]) &&
                      (rxf_wp_q[FIFO_W-1:0] == rxf_rp_q[FIFO_W-1:0]);
   assign rxf_re    = u.rd_uart & ~rxf_empty;
   assign rxf_we    = rx_done_q & (~rxf_full | rxf_re);
   assign ovr_set   = rx_done_q & rxf_full & ~rxf_re;

   always_ff @(posedge clk) begin
      if (rxf_we) rxf_mem_q[rxf_wp_q[FIFO_W-1:0]] <= rx_b_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rxf_wp_q <= '0;
         rxf_rp_q <= '0;
      end else begin
         if (rxf_we) rxf_wp_q <= rxf_wp_q + 1'b1;
         if (rxf_re) rxf_rp_q <= rxf_rp_q + 1'b1;
      end
   end

   // TX FSM; the line is registered from next-state so it never glitches
   state_e          tx_st_q, tx_st_d;
   logic [SW-1:0]   tx_s_q, tx_s_d;
   logic [NW-1:0]   tx_n_q, tx_n_d;
   logic [DBIT-1:0] tx_sh_q, tx_sh_d;
   logic            tx_pen_q, tx_pen_d;
   logic            tx_pbit_q, tx_pbit_d;
   logic            tx_q, tx_d;

   always_comb begin
      tx_st_d   = tx_st_q;
      tx_s_d    = tx_s_q;
      tx_n_d    = tx_n_q;
      tx_sh_d   = tx_sh_q;
      tx_pen_d  = tx_pen_q;
      tx_pbit_d = tx_pbit_q;
      tx_pop    = 1'b0;
      unique case (tx_st_q)
         StIdle: begin
            if (!txf_empty) begin
               tx_pop    = 1'b1;
               tx_sh_d   = txf_head;
               tx_s_d    = '0;
               tx_pen_d  = ^par_mode_in;
               tx_pbit_d = ^txf_head ^ par_mode_in[1];
               tx_st_d   = StStart;
            end
         end
         StStart: begin
            if (tick) begin
               if (tx_s_q == SBit) begin
                  tx_s_d  = '0;
                  tx_n_d  = '0;
                  tx_st_d = StData;
               end else begin
                  tx_s_d = tx_s_q + SW'(1);
               end
            end
         end
         StData: begin
            if (tick) begin
               if (tx_s_q == SBit) begin
                  tx_s_d  = '0;
                  tx_sh_d = tx_sh_q >> 1;
                  if (tx_n_q == NLast) tx_st_d = tx_pen_q ? StPar : StStop;
                  else                 tx_n_d  = tx_n_q + NW'(1);
               end else begin
                  tx_s_d = tx_s_q + SW'(1);
               end
            end
         end
         StPar: begin
            if (tick) begin
               if (tx_s_q == SBit) begin
                  tx_s_d  = '0;
                  tx_st_d = StStop;
               end else begin
                  tx_s_d = tx_s_q + SW'(1);
               end
            end
         end
         StStop: begin
            if (tick) begin
               if (tx_s_q == SStop) tx_st_d = StIdle;
               else                 tx_s_d  = tx_s_q + SW'(1);
            end
         end
         default: tx_st_d = StIdle;
      endcase

      case (tx_st_d)
         StStart: tx_d = 1'b0;
         StData:  tx_d = tx_sh_d[0];
         StPar:   tx_d = tx_pbit_d;
         default: tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_st_q   <= StIdle;
         tx_s_q    <= '0;
         tx_n_q    <= '0;
         tx_sh_q   <= '0;
         tx_pen_q  <= 1'b0;
         tx_pbit_q <= 1'b0;
         tx_q      <= 1'b1;
      end else begin
         tx_st_q   <= tx_st_d;
         tx_s_q    <= tx_s_d;
         tx_n_q    <= tx_n_d;
         tx_sh_q   <= tx_sh_d;
         tx_pen_q  <= tx_pen_d;
         tx_pbit_q <= tx_pbit_d;
         tx_q      <= tx_d;
      end
   end

   // Sticky errors: a set in the clearing cycle wins
   logic frame_err_q, overrun_err_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_err_q   <= 1'b0;
         overrun_err_q <= 1'b0;
      end else begin
         frame_err_q   <= rx_ferr_set | (frame_err_q & ~u.clr_err);
         overrun_err_q <= ovr_set | (overrun_err_q & ~u.clr_err);
      end
   end

`ifdef UART_CFG_PARITY_EN
   logic parity_err_q, perr_set;

   assign par_mode_in = u.par_mode;
   assign perr_set    = rx_done_q & (^rx_mode_q) & (rx_pbit_q != (^rx_b_q ^ rx_mode_q[1]));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) parity_err_q <= 1'b0;
      else        parity_err_q <= perr_set | (parity_err_q & ~u.clr_err);
   end

   assign u.parity_err = parity_err_q;
`else
   logic unused_par;

   assign par_mode_in  = 2'b00;
   assign unused_par   = ^{u.par_mode, rx_pbit_q};
   assign u.parity_err = 1'b0;
`endif

   assign u.tx          = tx_q;
   assign u.tx_full     = txf_full;
   assign u.tx_idle     = (tx_st_q == StIdle) & txf_empty;
   assign u.rx_empty    = rxf_empty;
   assign u.r_data      = rxf_mem_q[rxf_rp_q[FIFO_W-1:0]];
   assign u.frame_err   = frame_err_q;
   assign u.overrun_err = overrun_err_q;

endmodule

// File: tb/tb_uart_cfg.sv
// Directed bench for uart_cfg at dvsr=3 (64 clocks per bit), DBIT=8, FIFO_W=2.
module tb_uart_cfg;
   localparam int BT = 64;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic loop_en = 1'b0;
   logic rx_drv = 1'b1;
   int   n_pass = 0;
   int   n_total = 0;

   uart_cfg_if #(.DBIT(8), .DVSR_W(11)) bus ();

   uart_cfg #(.DBIT(8), .SB_TICK(16), .DVSR_W(11), .FIFO_W(2)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .u    (bus)
   );

   always #5 clk = ~clk;
   assign bus.rx = loop_en ? bus.tx : rx_drv;

   task automatic clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic push(input logic [7:0] d);
      bus.w_data  = d;
      bus.wr_uart = 1'b1;
      @(negedge clk);
      bus.wr_uart = 1'b0;
   endtask

   task automatic pop();
      bus.rd_uart = 1'b1;
      @(negedge clk);
      bus.rd_uart = 1'b0;
   endtask

   task automatic clr();
      bus.clr_err = 1'b1;
      @(negedge clk);
      bus.clr_err = 1'b0;
   endtask

   task automatic wait_tx(input logic val, input int budget, output int n);
      n = -1;
      for (int i = 1; i <= budget; i++) begin
         @(negedge clk);
         if (bus.tx === val) begin
            n = i;
            break;
         end
      end
   endtask

   task automatic wait_rx(input int budget, output int n);
      n = -1;
      for (int i = 0; i <= budget; i++) begin
         if (bus.rx_empty === 1'b0) begin
            n = i;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic wait_idle(input int budget, output int n);
      n = -1;
      for (int i = 0; i <= budget; i++) begin
         if (bus.tx_idle === 1'b1) begin
            n = i;
            break;
         end
         @(negedge clk);
      end
   endtask

   // Serial frame on rx_drv; bad_stop holds the stop bit low briefly then releases
   task automatic send_rx(input logic [7:0] d, input bit has_par, input bit pbit,
                          input bit bad_stop);
      rx_drv = 1'b0;
      clks(BT);
      for (int i = 0; i < 8; i++) begin
         rx_drv = d[i];
         clks(BT);
      end
      if (has_par) begin
         rx_drv = pbit;
         clks(BT);
      end
      if (bad_stop) begin
         rx_drv = 1'b0;
         clks(44);
         rx_drv = 1'b1;
         clks(BT);
      end else begin
         rx_drv = 1'b1;
         clks(BT + 16);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      clks(3);
      n_total++; if (bus.tx !== 1'b1) $display("FAIL rst_tx: got %b want 1", bus.tx); else n_pass++;
      n_total++;
      if (bus.tx_full !== 1'b0) $display("FAIL rst_tx_full: got %b want 0", bus.tx_full);
      else n_pass++;
      n_total++;
      if (bus.tx_idle !== 1'b1) $display("FAIL rst_tx_idle: got %b want 1", bus.tx_idle);
      else n_pass++;
      n_total++;
      if (bus.rx_empty !== 1'b1) $display("FAIL rst_rx_empty: got %b want 1", bus.rx_empty);
      else n_pass++;
      n_total++;
      if ({bus.frame_err, bus.parity_err, bus.overrun_err} !== 3'b000)
         $display("FAIL rst_errs: got %b want 000",
                  {bus.frame_err, bus.parity_err, bus.overrun_err});
      else n_pass++;
      rst_n = 1'b1;
      clks(10);
   endtask

   task automatic test_tx_frame();
      logic [7:0] d;
      logic       exp;
      int         n;
      d = 8'hA5;
      push(d);
      wait_tx(1'b0, 20, n);
      n_total++; if (n < 0) $display("FAIL tx_start_seen: got timeout want fall"); else n_pass++;
      clks(30);
      n_total++;
      if (bus.tx !== 1'b0) $display("FAIL tx_start_bit: got %b want 0", bus.tx); else n_pass++;
      wait_tx(1'b1, 60, n);
      n_total++; if (n < 0) $display("FAIL tx_bit0_rise: got timeout want rise"); else n_pass++;
      wait_tx(1'b0, 80, n);
      n_total++; if (n != BT) $display("FAIL tx_bit_width: got %0d want %0d", n, BT); else n_pass++;
      clks(BT / 2);
      for (int i = 1; i <= 8; i++) begin
         exp = (i < 8) ? d[i] : 1'b1;
         n_total++;
         if (bus.tx !== exp) $display("FAIL tx_bit%0d: got %b want %b", i, bus.tx, exp);
         else n_pass++;
         clks(BT);
      end
      n_total++;
      if (bus.tx_idle !== 1'b1) $display("FAIL tx_idle_after: got %b want 1", bus.tx_idle);
      else n_pass++;
   endtask

   task automatic test_loopback();
      logic [7:0] exp [3];
      int         n;
      exp[0] = 8'h00;
      exp[1] = 8'hFF;
      exp[2] = 8'h3C;
      loop_en = 1'b1;
      for (int i = 0; i < 3; i++) push(exp[i]);
      wait_rx(1000, n);
      n_total++;
      if (n <= 9 * BT || n >= 660) $display("FAIL lb_first_latency: got %0d want 577..659", n);
      else n_pass++;
      wait_idle(2500, n);
      n_total++; if (n < 0) $display("FAIL lb_tx_idle: got timeout want idle"); else n_pass++;
      clks(80);
      for (int i = 0; i < 3; i++) begin
         n_total++;
         if (bus.r_data !== exp[i]) $display("FAIL lb_data%0d: got %h want %h", i, bus.r_data, exp[i]);
         else n_pass++;
         pop();
      end
      n_total++;
      if (bus.rx_empty !== 1'b1) $display("FAIL lb_drained: got %b want 1", bus.rx_empty);
      else n_pass++;
      n_total++;
      if ({bus.frame_err, bus.overrun_err} !== 2'b00)
         $display("FAIL lb_errs: got %b want 00", {bus.frame_err, bus.overrun_err});
      else n_pass++;
   endtask

   task automatic test_tx_full();
      logic [7:0] exp [5];
      int         n;
      exp[0] = 8'h01;
      exp[1] = 8'hA1;
      exp[2] = 8'hA2;
      exp[3] = 8'hA3;
      exp[4] = 8'hA4;
      loop_en = 1'b1;
      push(exp[0]);
      clks(5);
      for (int i = 1; i <= 5; i++) push(8'hA0 + 8'(i));
      n_total++;
      if (bus.tx_full !== 1'b1) $display("FAIL txf_full: got %b want 1", bus.tx_full); else n_pass++;
      for (int i = 0; i < 5; i++) begin
         wait_rx(800, n);
         n_total++;
         if (n < 0 || bus.r_data !== exp[i])
            $display("FAIL txf_data%0d: got %h (wait %0d) want %h", i, bus.r_data, n, exp[i]);
         else n_pass++;
         pop();
      end
      wait_idle(800, n);
      clks(700);
      n_total++;
      if (n < 0 || bus.rx_empty !== 1'b1)
         $display("FAIL txf_fifth_dropped: got rx_empty=%b idle_wait=%0d want 1", bus.rx_empty, n);
      else n_pass++;
   endtask

   task automatic test_frame_err();
      loop_en = 1'b0;
      rx_drv  = 1'b1;
      clr();
      send_rx(8'h5A, 1'b0, 1'b0, 1'b1);
      clks(100);
      n_total++;
      if (bus.frame_err !== 1'b1) $display("FAIL ferr_set: got %b want 1", bus.frame_err);
      else n_pass++;
      n_total++;
      if (bus.rx_empty !== 1'b1) $display("FAIL ferr_discard: got %b want 1", bus.rx_empty);
      else n_pass++;
      clr();
      n_total++;
      if (bus.frame_err !== 1'b0) $display("FAIL ferr_clr: got %b want 0", bus.frame_err);
      else n_pass++;
      rx_drv = 1'b0;
      clks(16);
      rx_drv = 1'b1;
      clks(200);
      n_total++;
      if ({bus.rx_empty, bus.frame_err} !== 2'b10)
         $display("FAIL glitch: got empty/ferr=%b want 10", {bus.rx_empty, bus.frame_err});
      else n_pass++;
   endtask

   task automatic test_overrun();
      logic [7:0] d;
      loop_en = 1'b0;
      clr();
      for (int i = 1; i <= 5; i++) begin
         d = 8'(i * 8'h11);
         send_rx(d, 1'b0, 1'b0, 1'b0);
      end
      n_total++;
      if (bus.overrun_err !== 1'b1) $display("FAIL ovr_set: got %b want 1", bus.overrun_err);
      else n_pass++;
      for (int i = 1; i <= 4; i++) begin
         d = 8'(i * 8'h11);
         n_total++;
         if (bus.r_data !== d) $display("FAIL ovr_data%0d: got %h want %h", i, bus.r_data, d);
         else n_pass++;
         pop();
      end
      n_total++;
      if (bus.rx_empty !== 1'b1) $display("FAIL ovr_drained: got %b want 1", bus.rx_empty);
      else n_pass++;
      clr();
      n_total++;
      if (bus.overrun_err !== 1'b0) $display("FAIL ovr_clr: got %b want 0", bus.overrun_err);
      else n_pass++;
   endtask

`ifdef UART_CFG_PARITY_EN
   task automatic test_parity();
      int n;
      loop_en      = 1'b0;
      bus.par_mode = 2'b01;
      clr();
      send_rx(8'h81, 1'b1, 1'b1, 1'b0);
      n_total++;
      if (bus.rx_empty !== 1'b0 || bus.r_data !== 8'h81)
         $display("FAIL par_byte: got empty=%b data=%h want 0/81", bus.rx_empty, bus.r_data);
      else n_pass++;
      n_total++;
      if (bus.parity_err !== 1'b1) $display("FAIL par_err_set: got %b want 1", bus.parity_err);
      else n_pass++;
      clr();
      n_total++;
      if (bus.parity_err !== 1'b0) $display("FAIL par_err_clr: got %b want 0", bus.parity_err);
      else n_pass++;
      pop();
      loop_en      = 1'b1;
      bus.par_mode = 2'b10;
      push(8'h3C);
      wait_rx(900, n);
      n_total++;
      if (n < 0 || bus.r_data !== 8'h3C || bus.parity_err !== 1'b0)
         $display("FAIL par_odd_lb: got data=%h perr=%b want 3C/0", bus.r_data, bus.parity_err);
      else n_pass++;
      pop();
      wait_idle(200, n);
      bus.par_mode = 2'b00;
   endtask
`else
   task automatic test_parity();
      loop_en      = 1'b0;
      bus.par_mode = 2'b01;
      clr();
      send_rx(8'h81, 1'b0, 1'b0, 1'b0);
      n_total++;
      if (bus.rx_empty !== 1'b0 || bus.r_data !== 8'h81)
         $display("FAIL nopar_byte: got empty=%b data=%h want 0/81", bus.rx_empty, bus.r_data);
      else n_pass++;
      n_total++;
      if ({bus.parity_err, bus.frame_err} !== 2'b00)
         $display("FAIL nopar_errs: got %b want 00", {bus.parity_err, bus.frame_err});
      else n_pass++;
      pop();
      bus.par_mode = 2'b00;
   endtask
`endif

   task automatic test_reset_mid();
      int n;
      loop_en = 1'b1;
      push(8'hF0);
      push(8'h12);
      wait_tx(1'b0, 20, n);
      clks(BT + 2 * BT + BT / 2);
      #2 rst_n = 1'b0;
      #1;
      n_total++;
      if (bus.tx !== 1'b1) $display("FAIL rmid_tx: got %b want 1", bus.tx); else n_pass++;
      n_total++;
      if ({bus.tx_full, bus.tx_idle, bus.rx_empty} !== 3'b011)
         $display("FAIL rmid_flags: got %b want 011", {bus.tx_full, bus.tx_idle, bus.rx_empty});
      else n_pass++;
      clks(3);
      rst_n = 1'b1;
      clks(20);
      push(8'h55);
      wait_rx(900, n);
      n_total++;
      if (n < 0 || bus.r_data !== 8'h55)
         $display("FAIL rmid_data: got %h (wait %0d) want 55", bus.r_data, n);
      else n_pass++;
      n_total++;
      if (bus.frame_err !== 1'b0) $display("FAIL rmid_ferr: got %b want 0", bus.frame_err);
      else n_pass++;
      pop();
      clks(700);
      n_total++;
      if (bus.rx_empty !== 1'b1) $display("FAIL rmid_flushed: got %b want 1", bus.rx_empty);
      else n_pass++;
   endtask

   initial begin
      bus.dvsr     = 11'd3;
      bus.par_mode = 2'b00;
      bus.wr_uart  = 1'b0;
      bus.w_data   = 8'h00;
      bus.rd_uart  = 1'b0;
      bus.clr_err  = 1'b0;
      test_reset();
      test_tx_frame();
      test_loopback();
      test_tx_full();
      test_frame_err();
      test_overrun();
      test_parity();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
